led_pattern_sched: RTL and testbench

// - Sequences the 16-LED bank. Selects the pattern mode, the step rate and run/pause from single-cycle command pulses.
// - Sits between the button-conditioning logic (debounce plus one-shot pulse) and the LED pins.
// - Replaces the fixed free-running left shifter with a configurable, pausable pattern engine.

---
 rtl/led_pattern_sched_pkg.sv | 29 ++
 rtl/led_pattern_sched_if.sv | 25 ++
 rtl/led_pattern_sched_tick_gen.sv | 29 ++
 rtl/led_pattern_sched.sv | 149 ++++++++++++++
 tb/tb_led_pattern_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_sched_pkg.sv
// led_pattern_sched shared definitions.
// Mode and direction encodings, seed patterns, speed limit.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_e;

  localparam logic [15:0] SEED_SHL    = 16'h0001;
  localparam logic [15:0] SEED_SHR    = 16'h8000;
  localparam logic [15:0] SEED_BOUNCE = 16'h0001;
  localparam logic [15:0] SEED_BLINK  = 16'hFFFF;

  localparam logic [2:0] SPD_MAX = 3'd7;

  // Mode sequence wraps BLINK back to SHL.
  function automatic mode_e mode_next(mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_pattern_sched_if.sv
// Command pulses in, LED bank and status out.
// slave = scheduler side, master = button/consumer side.
interface led_pattern_sched_if #(
  parameter int N_LED = 16
);
  logic             cmd_mode;
  logic             cmd_fast;
  logic             cmd_slow;
  logic             cmd_pause;
  logic [N_LED-1:0] led;
  logic [1:0]       mode;
  logic [2:0]       speed;
  logic             running;
  logic             step;

  modport master (
    output cmd_mode, cmd_fast, cmd_slow, cmd_pause,
    input  led, mode, speed, running, step
  );

  modport slave (
    input  cmd_mode, cmd_fast, cmd_slow, cmd_pause,
    output led, mode, speed, running, step
  );
endinterface

// File: rtl/led_pattern_sched_tick_gen.sv
// Loadable step-rate down-counter.
// Ticks while enabled at zero, then reloads.
module led_tick_gen #(
  parameter int BASE_DIV = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_reload,
  input  logic [BASE_DIV-1:0] i_period_m1,
  output logic                o_tick
);

  logic [BASE_DIV-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Count down when enabled; reload on command or on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '1;
    end else if (i_reload || o_tick) begin
      r_cnt <= i_period_m1;
    end else if (i_en) begin
      r_cnt <= r_cnt - BASE_DIV'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sched.sv
// Pausable, rate-selectable 16-LED pattern sequencer.
// Commands are single-cycle pulses; all outputs registered.
module led_pattern_sched
  import led_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int BASE_DIV = 24
) (
  input logic               clk,
  input logic               rst,
  led_pattern_sched_if.slave bus
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  localparam logic [N_LED-1:0] L_LSB = N_LED'(1);
  localparam logic [N_LED-1:0] L_MSB = L_LSB << (N_LED - 1);

  state_e           r_state;
  logic             r_running;
  logic [N_LED-1:0] r_led;
  mode_e            r_mode;
  logic [2:0]       r_speed;
  dir_e             r_dir;
  logic             r_step;

  logic                w_tick;
  logic                w_reload;
  logic [2:0]          w_spd_nxt;
  logic [BASE_DIV-1:0] w_period_m1;
  mode_e               w_mode_nxt;
  logic [N_LED-1:0]    w_seed;
  logic [N_LED-1:0]    w_pat;
  dir_e                w_dir_nxt;

  assign w_mode_nxt = mode_next(r_mode);

  // Any accepted rate command (one of fast/slow alone) restarts the
  // period, even when the speed is already at its limit.
  assign w_reload = bus.cmd_mode | (bus.cmd_fast ^ bus.cmd_slow);

  // Saturating speed update; fast+slow together cancel.
  always_comb begin
    w_spd_nxt = r_speed;
    if (bus.cmd_fast && !bus.cmd_slow && r_speed != SPD_MAX)
      w_spd_nxt = r_speed + 3'd1;
    else if (bus.cmd_slow && !bus.cmd_fast && r_speed != 3'd0)
      w_spd_nxt = r_speed - 3'd1;
  end

  assign w_period_m1 = BASE_DIV'(
    (64'd1 << (BASE_DIV - int'(w_spd_nxt))) - 64'd1);

  // Seed shown when entering the next mode.
  always_comb begin
    w_seed = N_LED'(SEED_SHL);
    unique case (w_mode_nxt)
      MODE_SHL:    w_seed = N_LED'(SEED_SHL);
      MODE_SHR:    w_seed = N_LED'(SEED_SHR);
      MODE_BOUNCE: w_seed = N_LED'(SEED_BOUNCE);
      MODE_BLINK:  w_seed = N_LED'(SEED_BLINK);
    endcase
  end

  // Pattern value after one tick in the current mode.
  always_comb begin
    w_pat     = r_led;
    w_dir_nxt = r_dir;
    unique case (r_mode)
      MODE_SHL: w_pat = {r_led[N_LED-2:0], r_led[N_LED-1]};
      MODE_SHR: w_pat = {r_led[0], r_led[N_LED-1:1]};
      MODE_BOUNCE: begin
        if (r_dir == DIR_L) begin
          if (r_led == L_MSB) begin
            w_pat     = L_MSB >> 1;
            w_dir_nxt = DIR_R;
          end else begin
            w_pat = r_led << 1;
          end
        end else begin
          if (r_led == L_LSB) begin
            w_pat     = L_LSB << 1;
            w_dir_nxt = DIR_L;
          end else begin
            w_pat = r_led >> 1;
          end
        end
      end
      MODE_BLINK: w_pat = ~r_led;
    endcase
  end

  led_tick_gen #(
    .BASE_DIV (BASE_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_running),
    .i_reload    (w_reload),
    .i_period_m1 (w_period_m1),
    .o_tick      (w_tick)
  );

  // Run/pause FSM plus mode, speed and pattern registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_running <= 1'b1;
      r_led     <= L_LSB;
      r_mode    <= MODE_SHL;
      r_speed   <= 3'd0;
      r_dir     <= DIR_L;
      r_step    <= 1'b0;
    end else begin
      r_speed <= w_spd_nxt;
      r_step  <= w_tick & ~bus.cmd_mode;
      if (bus.cmd_pause) begin
        unique case (r_state)
          ST_RUN: begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
          ST_PAUSE: begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        endcase
      end
      if (bus.cmd_mode) begin
        r_mode <= w_mode_nxt;
        r_led  <= w_seed;
        r_dir  <= DIR_L;
      end else if (w_tick) begin
        r_led <= w_pat;
        r_dir <= w_dir_nxt;
      end
    end
  end

  assign bus.led     = r_led;
  assign bus.mode    = r_mode;
  assign bus.speed   = r_speed;
  assign bus.running = r_running;
  assign bus.step    = r_step;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched (BASE_DIV=8).
// Directed scenarios plus random commands against a position-based model.
module tb_led_pattern_sched;

  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  led_pattern_sched_if #(.N_LED(16)) bus();

  led_pattern_sched #(
    .N_LED    (16),
    .BASE_DIV (BD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: LED described by a lit position / bounce phase / blink flag;
  // m_rem = RUN cycles left until the next step update.
  int m_mode, m_speed, m_pos, m_phase, m_rem;
  bit m_run, m_blk, m_step;

  function automatic int period(int s);
    return 1 << (BD - s);
  endfunction

  function automatic logic [15:0] m_led();
    int p;
    case (m_mode)
      0, 1: return 16'(1 << m_pos);
      2: begin
        p = (m_phase <= 15) ? m_phase : 30 - m_phase;
        return 16'(1 << p);
      end
      default: return m_blk ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_speed = 0; m_pos = 0; m_phase = 0;
    m_blk = 1'b1; m_run = 1'b1; m_step = 1'b0;
    m_rem = period(0);
  endtask

  task automatic m_edge(bit cm, bit cf, bit cs, bit cp);
    bit tick;
    int ns;
    tick = m_run && (m_rem == 1);
    ns = m_speed;
    if (cf && !cs && ns < 7) ns++;
    else if (cs && !cf && ns > 0) ns--;
    if (cm || (cf ^ cs) || tick) m_rem = period(ns);
    else if (m_run) m_rem--;
    if (cm) begin
      m_mode  = (m_mode + 1) % 4;
      m_pos   = (m_mode == 1) ? 15 : 0;
      m_phase = 0;
      m_blk   = 1'b1;
    end else if (tick) begin
      case (m_mode)
        0: m_pos = (m_pos + 1) % 16;
        1: m_pos = (m_pos + 15) % 16;
        2: m_phase = (m_phase + 1) % 30;
        default: m_blk = !m_blk;
      endcase
    end
    m_step  = tick && !cm;
    m_speed = ns;
    if (cp) m_run = !m_run;
  endtask

  task automatic drive(bit cm, bit cf, bit cs, bit cp);
    bus.cmd_mode  = cm;
    bus.cmd_fast  = cf;
    bus.cmd_slow  = cs;
    bus.cmd_pause = cp;
    @(posedge clk);
    m_edge(cm, cf, cs, cp);
    #1;
    bus.cmd_mode  = 1'b0;
    bus.cmd_fast  = 1'b0;
    bus.cmd_slow  = 1'b0;
    bus.cmd_pause = 1'b0;
  endtask

  task automatic do_reset(bit cm, bit cf);
    rst = 1'b1;
    bus.cmd_mode  = cm;
    bus.cmd_fast  = cf;
    bus.cmd_slow  = 1'b0;
    bus.cmd_pause = 1'($urandom_range(0, 1));
    @(posedge clk);
    m_reset();
    #1;
    rst = 1'b0;
    bus.cmd_mode  = 1'b0;
    bus.cmd_fast  = 1'b0;
    bus.cmd_pause = 1'b0;
  endtask

  // Idle until a step pulse; n = cycles taken, 0 if budget expired.
  task automatic wait_step(int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      drive(0, 0, 0, 0);
      if (bus.step === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1, 1);
    do_reset(1, 1);
    checks++;
    if (bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL reset_led got=%h exp=0001", bus.led);
    end
    checks++;
    if (bus.mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_mode got=%0d exp=0", bus.mode);
    end
    checks++;
    if (bus.speed !== 3'd0) begin
      failures++;
      $display("FAIL reset_speed got=%0d exp=0", bus.speed);
    end
    checks++;
    if (bus.running !== 1'b1 || bus.step !== 1'b0) begin
      failures++;
      $display("FAIL reset_run_step got=%b%b exp=10",
               bus.running, bus.step);
    end
  endtask

  task automatic test_idle_run();
    int n;
    do_reset(0, 0);
    wait_step(300, n);
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL idle_first_step got=%0d exp=256", n);
    end
    checks++;
    if (bus.led !== 16'h0002) begin
      failures++;
      $display("FAIL idle_first_led got=%h exp=0002", bus.led);
    end
    wait_step(300, n);
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL idle_interval got=%0d exp=256", n);
    end
    for (int k = 0; k < 14; k++) wait_step(300, n);
    checks++;
    if (bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL idle_wrap16 got=%h exp=0001", bus.led);
    end
  endtask

  task automatic test_speed();
    int n;
    do_reset(0, 0);
    repeat (3) drive(0, 1, 0, 0);
    checks++;
    if (bus.speed !== 3'd3) begin
      failures++;
      $display("FAIL speed_fast3 got=%0d exp=3", bus.speed);
    end
    wait_step(100, n);
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL speed3_first got=%0d exp=32", n);
    end
    wait_step(100, n);
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL speed3_interval got=%0d exp=32", n);
    end
    repeat (10) drive(0, 1, 0, 0);
    checks++;
    if (bus.speed !== 3'd7) begin
      failures++;
      $display("FAIL speed_sat_hi got=%0d exp=7", bus.speed);
    end
    wait_step(10, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL speed7_period got=%0d exp=2", n);
    end
    repeat (10) drive(0, 0, 1, 0);
    checks++;
    if (bus.speed !== 3'd0) begin
      failures++;
      $display("FAIL speed_sat_lo got=%0d exp=0", bus.speed);
    end
  endtask

  task automatic test_bounce();
    int n, p;
    logic [15:0] exp;
    do_reset(0, 0);
    repeat (7) drive(0, 1, 0, 0);
    repeat (2) drive(1, 0, 0, 0);
    checks++;
    if (bus.mode !== 2'd2 || bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL bounce_enter got=%0d/%h exp=2/0001",
               bus.mode, bus.led);
    end
    for (int k = 1; k <= 31; k++) begin
      wait_step(10, n);
      p = k % 30;
      exp = 16'(1 << ((p <= 15) ? p : 30 - p));
      checks++;
      if (n == 0 || bus.led !== exp) begin
        failures++;
        $display("FAIL bounce_step%0d got=%h exp=%h", k, bus.led, exp);
      end
    end
  endtask

  task automatic test_pause();
    int n, bad;
    logic [15:0] held;
    do_reset(0, 0);
    wait_step(300, n);
    repeat (99) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (bus.running !== 1'b0) begin
      failures++;
      $display("FAIL pause_enter got=%b exp=0", bus.running);
    end
    held = bus.led;
    bad = 0;
    repeat (1000) begin
      drive(0, 0, 0, 0);
      if (bus.led !== held || bus.step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pause_hold got=%0d exp=0 changed cycles", bad);
    end
    drive(0, 0, 0, 1);
    wait_step(300, n);
    checks++;
    if (n != 156) begin
      failures++;
      $display("FAIL pause_resume got=%0d exp=156", n);
    end
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    checks++;
    if (bus.mode !== 2'd1 || bus.led !== 16'h8000 ||
        bus.running !== 1'b0) begin
      failures++;
      $display("FAIL pause_mode got=%0d/%h/%b exp=1/8000/0",
               bus.mode, bus.led, bus.running);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (bus.speed !== 3'd1 || bus.led !== 16'h8000) begin
      failures++;
      $display("FAIL pause_fast got=%0d/%h exp=1/8000",
               bus.speed, bus.led);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_coincide();
    do_reset(0, 0);
    repeat (2) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    checks++;
    if (bus.speed !== 3'd2) begin
      failures++;
      $display("FAIL both_fast_slow got=%0d exp=2", bus.speed);
    end
    for (int i = 0; i < 100 && !(m_run && m_rem == 1); i++)
      drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    checks++;
    if (bus.step !== 1'b0 || bus.led !== 16'h8000 ||
        bus.mode !== 2'd1) begin
      failures++;
      $display("FAIL mode_on_tick got=%b/%h/%0d exp=0/8000/1",
               bus.step, bus.led, bus.mode);
    end
    for (int i = 0; i < 100 && !(m_run && m_rem == 1); i++)
      drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (bus.step !== 1'b1 || bus.led !== 16'h4000 ||
        bus.running !== 1'b0) begin
      failures++;
      $display("FAIL pause_on_tick got=%b/%h/%b exp=1/4000/0",
               bus.step, bus.led, bus.running);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(0, 0);
    repeat (3) drive(1, 0, 0, 0);
    repeat (7) drive(0, 1, 0, 0);
    wait_step(10, n);
    wait_step(10, n);
    do_reset(1, 1);
    checks++;
    if (bus.led !== 16'h0001 || bus.mode !== 2'd0 ||
        bus.speed !== 3'd0 || bus.running !== 1'b1 ||
        bus.step !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%0d/%0d/%b/%b exp=0001/0/0/1/0",
               bus.led, bus.mode, bus.speed, bus.running, bus.step);
    end
  endtask

  task automatic test_random();
    bit cm, cf, cs, cp;
    int shown;
    logic [23:0] got, exp;
    shown = 0;
    do_reset(0, 0);
    for (int i = 0; i < 4000; i++) begin
      cm = ($urandom_range(0, 49) == 0);
      cf = ($urandom_range(0, 19) == 0);
      cs = ($urandom_range(0, 19) == 0);
      cp = ($urandom_range(0, 59) == 0);
      drive(cm, cf, cs, cp);
      got = {bus.led, bus.mode, bus.speed, bus.running, bus.step};
      exp = {m_led(), 2'(m_mode), 3'(m_speed), m_run, m_step};
      checks++;
      if (got !== exp) begin
        failures++;
        if (shown < 10)
          $display("FAIL random_cyc%0d got=%h exp=%h", i, got, exp);
        shown++;
      end
    end
  endtask

  initial begin
    bus.cmd_mode  = 1'b0;
    bus.cmd_fast  = 1'b0;
    bus.cmd_slow  = 1'b0;
    bus.cmd_pause = 1'b0;
    m_reset();
    test_reset();
    test_idle_run();
    test_speed();
    test_bounce();
    test_pause();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
